weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 The block SHALL have parameter X_PE, default 16, PE count per mesh.
REQ-002 The block SHALL have parameter X_MESH, default 16, mesh count.
REQ-003 The block SHALL have parameter ADDR_LEN, default 16, weight-bank address width.
REQ-004 The block SHALL have parameter DATA_LEN, default 64, per-bank word width.
REQ-005 The block SHALL have parameter BUFFER_NUM, default 8*X_PE*X_MESH/DATA_LEN (32), bank count.
REQ-006 The block SHALL define derived constant G = BUFFER_NUM/8 (4), the beats needed per bank address.
REQ-007 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle pulse that starts a load.
- cfg_base_addr  in  ADDR_LEN  first bank address.
- cfg_len  in  ADDR_LEN  number of bank addresses to fill.
- s_valid  in  1  input beat valid.
- s_data  in  DATA_LEN*8  512-bit input beat.
- s_ready  out  1  block accepts a beat.
- data_wr  out  DATA_LEN*8  write data to the weight buffer.
- wr_addr  out  ADDR_LEN  write address to the weight buffer.
- wr_en  out  BUFFER_NUM  per-bank write enables.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD and DONE, and SHALL return to IDLE after any reset.
REQ-009 In IDLE, cfg_start=1 SHALL latch cfg_base_addr and cfg_len, clear the group and address counters, and go to LOAD; if cfg_len=0 it SHALL go directly to DONE instead.
REQ-010 s_ready SHALL be 1 only in LOAD.
REQ-011 A beat is accepted on any cycle with s_valid=1 and s_ready=1; there SHALL be no other accept condition.
REQ-012 For a beat accepted at cycle t, cycle t+1 SHALL show data_wr=s_data, wr_addr=current address, and wr_en bits [8g+7:8g]=all ones with all other bits 0, where g is the current group index; all outputs are registered.
REQ-013 wr_en SHALL be all zero on every cycle that does not follow an accepted beat; data_wr and wr_addr hold their last value.
REQ-014 The group index SHALL advance 0..G-1 on each accept; after group G-1 it SHALL reset to 0 and the address SHALL advance by 1.
REQ-015 Address arithmetic SHALL be ADDR_LEN bits, modulo 2^ADDR_LEN, so 0xFFFF+1=0x0000.
REQ-016 The beat that completes group G-1 of address number cfg_len SHALL move the FSM to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, coinciding with the final write on wr_en; the FSM then returns to IDLE.
REQ-018 For a cfg_len=0 start, done SHALL pulse in the cycle after cfg_start, with no wr_en asserted.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 cfg_start SHALL be ignored in LOAD and in DONE; the latched configuration SHALL stay unchanged.
REQ-021 The block SHALL not buffer beats; input stalls (s_valid=0) SHALL pause progress with no limit on duration.

Reset
REQ-022 On rst=1 at a clock edge, the next cycle SHALL show: state IDLE, s_ready=0, wr_en=0, busy=0, done=0, data_wr=0, wr_addr=0, and all counters 0.
REQ-023 Reset mid-LOAD SHALL abandon the load without producing done; a later cfg_start SHALL restart at group 0 of the new base address.
REQ-024 Reset SHALL take priority over cfg_start and over a beat accept in the same cycle.

Verification
REQ-025 Bench SHALL cover: base=0x0010, len=2, 8 back-to-back beats D0..D7 -> wr_addr 0x10 with wr_en 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000 (D0..D3), then 0x11 with the same pattern (D4..D7); done=1 with the 8th write; s_ready=0 afterwards.
REQ-026 Bench SHALL cover: same load with s_valid toggling 1,0,1,0 -> exactly one wr_en pulse per accepted beat, wr_en=0 in gap cycles, same final address and data sequence.
REQ-027 Bench SHALL cover: base=0xFFFF, len=2 -> first 4 writes at 0xFFFF, next 4 at 0x0000, then done.
REQ-028 Bench SHALL cover: cfg_len=0 -> done=1 and busy=1 in cycle t+1, IDLE at t+2, s_ready and wr_en never asserted.
REQ-029 Bench SHALL cover: rst=1 after 3 accepted beats -> wr_en=0 and busy=0 the next cycle, no done; a new start at base=0x0020 -> first write at 0x20 with wr_en=0x000000FF.
REQ-030 Bench SHALL cover: cfg_start with a different base pulsed mid-LOAD -> ignored, original address sequence completes unchanged.

Source files
------------

// File: rtl/weight_loader.sv
// Streams 512-bit beats into a banked weight buffer: each bank address is filled
// by G consecutive beats, each beat enabling one group of 8 banks.
module weight_loader #(
    parameter int X_PE       = 16,
    parameter int X_MESH     = 16,
    parameter int ADDR_LEN   = 16,
    parameter int DATA_LEN   = 64,
    parameter int BUFFER_NUM = 8 * X_PE * X_MESH / DATA_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_LEN-1:0]   cfg_base_addr,
    input  logic [ADDR_LEN-1:0]   cfg_len,
    input  logic                  s_valid,
    input  logic [DATA_LEN*8-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_LEN*8-1:0] data_wr,
    output logic [ADDR_LEN-1:0]   wr_addr,
    output logic [BUFFER_NUM-1:0] wr_en,
    output logic                  busy,
    output logic                  done
);

    localparam int G  = BUFFER_NUM / 8;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r, state_nx_s;
    logic [GW-1:0]         grp_r, grp_nx_s;
    logic [ADDR_LEN-1:0]   addr_r, addr_nx_s;
    logic [ADDR_LEN-1:0]   cnt_r, cnt_nx_s;
    logic [ADDR_LEN-1:0]   len_r, len_nx_s;
    logic [DATA_LEN*8-1:0] data_nx_s, data_wr_r;
    logic [ADDR_LEN-1:0]   waddr_nx_s, wr_addr_r;
    logic [BUFFER_NUM-1:0] wen_nx_s, wr_en_r;
    logic                  s_ready_r, busy_r, done_r;
    logic                  accept_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, counter update and write-port decode
    always_comb begin
        state_nx_s = state_r;
        grp_nx_s   = grp_r;
        addr_nx_s  = addr_r;
        cnt_nx_s   = cnt_r;
        len_nx_s   = len_r;
        data_nx_s  = data_wr_r;
        waddr_nx_s = wr_addr_r;
        wen_nx_s   = {BUFFER_NUM{1'b0}};
        accept_s   = s_valid && s_ready_r;

        case (state_r)
            IDLE: begin
                if (cfg_start) begin
                    len_nx_s   = cfg_len;
                    addr_nx_s  = cfg_base_addr;
                    grp_nx_s   = {GW{1'b0}};
                    cnt_nx_s   = {ADDR_LEN{1'b0}};
                    state_nx_s = (cfg_len == {ADDR_LEN{1'b0}}) ? DONE : LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    data_nx_s  = s_data;
                    waddr_nx_s = addr_r;
                    for (int g = 0; g < G; g++) begin
                        if (grp_r == GW'(g)) begin
                            wen_nx_s[8*g +: 8] = 8'hFF;
                        end else begin
                            wen_nx_s[8*g +: 8] = 8'h00;
                        end
                    end
                    // Last group of an address: wrap group, step address (mod 2^ADDR_LEN)
                    if (grp_r == G_LAST) begin
                        grp_nx_s  = {GW{1'b0}};
                        addr_nx_s = addr_r + ADDR_LEN'(1);
                        cnt_nx_s  = cnt_r + ADDR_LEN'(1);
                        if (cnt_r == len_r - ADDR_LEN'(1)) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = LOAD;
                        end
                    end else begin
                        grp_nx_s = grp_r + GW'(1);
                    end
                end else begin
                    state_nx_s = LOAD;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Counters and registered outputs; status flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_r     <= {GW{1'b0}};
            addr_r    <= {ADDR_LEN{1'b0}};
            cnt_r     <= {ADDR_LEN{1'b0}};
            len_r     <= {ADDR_LEN{1'b0}};
            data_wr_r <= {(DATA_LEN*8){1'b0}};
            wr_addr_r <= {ADDR_LEN{1'b0}};
            wr_en_r   <= {BUFFER_NUM{1'b0}};
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            grp_r     <= grp_nx_s;
            addr_r    <= addr_nx_s;
            cnt_r     <= cnt_nx_s;
            len_r     <= len_nx_s;
            data_wr_r <= data_nx_s;
            wr_addr_r <= waddr_nx_s;
            wr_en_r   <= wen_nx_s;
            s_ready_r <= (state_nx_s == LOAD);
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == DONE);
        end
    end

    assign s_ready = s_ready_r;
    assign data_wr = data_wr_r;
    assign wr_addr = wr_addr_r;
    assign wr_en   = wr_en_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a per-load reference list of expected writes
// is queued at stimulus time and a negedge monitor pops and compares each write.
module tb_weight_loader;

    localparam int AL = 16;
    localparam int DW = 512;
    localparam int BN = 32;
    localparam int G  = 4;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic [AL-1:0] cfg_base_addr;
    logic [AL-1:0] cfg_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] data_wr;
    logic [AL-1:0] wr_addr;
    logic [BN-1:0] wr_en;
    logic          busy;
    logic          done;

    weight_loader dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_len       (cfg_len),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .data_wr       (data_wr),
        .wr_addr       (wr_addr),
        .wr_en         (wr_en),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [AL-1:0] a;
        logic [DW-1:0] d;
        logic [BN-1:0] w;
        logic          dn;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] beats[$];
    exp_t          mon_e;
    int            errors   = 0;
    int            checks   = 0;
    int            done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (wr_en !== {BN{1'b0}} && !$isunknown(wr_en)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h wr_en=%0h expected no write", wr_addr, wr_en);
            end else begin
                mon_e = sb.pop_front();
                if (wr_addr !== mon_e.a || data_wr !== mon_e.d || wr_en !== mon_e.w || done !== mon_e.dn) begin
                    errors++;
                    $display("FAIL write: got addr=%0h wr_en=%0h done=%0b data=%0h expected addr=%0h wr_en=%0h done=%0b data=%0h",
                             wr_addr, wr_en, done, data_wr, mon_e.a, mon_e.w, mon_e.dn, mon_e.d);
                end
            end
        end
    end

    // Reference: beat i lands at base + i/G, bank group i%G; last beat carries done
    task automatic build(input logic [AL-1:0] base, input logic [AL-1:0] len);
        int n;
        n = int'(len) * G;
        beats.delete();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] d;
            exp_t e;
            for (int j = 0; j < DW / 32; j++) d[32*j +: 32] = $urandom;
            beats.push_back(d);
            e.a  = base + AL'(i / G);
            e.d  = d;
            e.w  = 32'h0000_00FF << (8 * (i % G));
            e.dn = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    // mode 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random valid
    task automatic send(input int n, input int mode, input int inj);
        int   sent = 0;
        int   cyc  = 0;
        bit   injected = 1'b0;
        logic v, rdy;
        while (sent < n && cyc < 400 * (n + 1)) begin
            @(negedge clk);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
            s_valid = v;
            s_data  = beats[sent];
            if (sent == inj && !injected) begin
                cfg_start     = 1'b1;
                cfg_base_addr = 16'h0099;
                cfg_len       = 16'h0001;
                injected      = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            rdy = s_ready;
            @(posedge clk);
            if (v && rdy) sent++;
            cyc++;
        end
        if (sent < n) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got %0d beats accepted expected %0d", sent, n);
        end
    endtask

    task automatic run_load(input logic [AL-1:0] base, input logic [AL-1:0] len, input int mode, input int inj);
        int d0;
        build(base, len);
        d0 = done_cnt;
        @(negedge clk);
        cfg_start = 1'b1; cfg_base_addr = base; cfg_len = len;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("busy_after_start", DW'(busy), DW'(1'b1));
        chk("ready_in_load", DW'(s_ready), DW'(1'b1));
        send(int'(len) * G, mode, inj);
        @(negedge clk);
        s_valid = 1'b0;
        if (inj >= 0) begin
            cfg_start = 1'b1; cfg_base_addr = 16'h0099; cfg_len = 16'h0001;
        end
        #1;
        chk("all_writes_seen", DW'(sb.size()), DW'(0));
        chk("done_with_last", DW'(done), DW'(1'b1));
        chk("ready_low_done", DW'(s_ready), DW'(1'b0));
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("idle_busy", DW'(busy), DW'(1'b0));
        chk("idle_done", DW'(done), DW'(1'b0));
        chk("done_count", DW'(done_cnt - d0), DW'(1));
    endtask

    initial begin
        int d0;
        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = 16'h0000; cfg_len = 16'h0000;
        s_valid = 1'b0; s_data = {DW{1'b0}};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", DW'(s_ready), DW'(0));
        chk("rst_wr_en", DW'(wr_en), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_data", data_wr, DW'(0));
        chk("rst_addr", DW'(wr_addr), DW'(0));
        rst = 1'b0;

        run_load(16'h0010, 16'h0002, 0, -1);
        run_load(16'h0010, 16'h0002, 1, -1);
        run_load(16'hFFFF, 16'h0002, 0, -1);

        // Zero-length load: done in the next cycle, no writes, back to idle after
        d0 = done_cnt;
        @(negedge clk);
        cfg_start = 1'b1; cfg_base_addr = 16'h0050; cfg_len = 16'h0000;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("len0_done", DW'(done), DW'(1));
        chk("len0_busy", DW'(busy), DW'(1));
        chk("len0_ready", DW'(s_ready), DW'(0));
        chk("len0_wr_en", DW'(wr_en), DW'(0));
        @(negedge clk);
        #1;
        chk("len0_idle_busy", DW'(busy), DW'(0));
        chk("len0_idle_done", DW'(done), DW'(0));
        chk("len0_idle_ready", DW'(s_ready), DW'(0));
        chk("len0_done_count", DW'(done_cnt - d0), DW'(1));

        // Reset after three accepted beats abandons the load
        build(16'h0030, 16'h0002);
        d0 = done_cnt;
        @(negedge clk);
        cfg_start = 1'b1; cfg_base_addr = 16'h0030; cfg_len = 16'h0002;
        @(negedge clk);
        cfg_start = 1'b0;
        send(3, 0, -1);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_wr_en", DW'(wr_en), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        chk("abort_done", DW'(done), DW'(0));
        chk("abort_written", DW'(sb.size()), DW'(5));
        chk("abort_no_done", DW'(done_cnt - d0), DW'(0));
        sb.delete();
        rst = 1'b0;
        run_load(16'h0020, 16'h0001, 0, -1);

        // cfg_start mid-load and during done must be ignored
        run_load(16'h0040, 16'h0003, 0, 5);

        for (int k = 0; k < 4; k++) begin
            run_load(16'($urandom), 16'($urandom_range(1, 3)), 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
